// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, FSM states, lane helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    SizeB  = 3'b000,
    SizeH  = 3'b001,
    SizeW  = 3'b010,
    SizeBu = 3'b100,
    SizeHu = 3'b101
  } lsu_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StResp
  } lsu_state_e;

  // Byte offset of the accessed lane; misaligned halfword/word offsets round down.
  function automatic logic [1:0] lane_offset(input logic [2:0] size, input logic [1:0] lo);
    case (size[1:0])
      2'b00:   return lo;
      2'b01:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] size, input logic [1:0] lo);
    case (size[1:0])
      2'b00:   return 4'b0001 << lane_offset(size, lo);
      2'b01:   return 4'b0011 << lane_offset(size, lo);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    return ((size[1:0] == 2'b01) && lo[0]) || ((size[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction and sign/zero extension for loads, and lane merging for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [1:0]  off;
  logic [3:0]  sel;
  logic [31:0] shifted;
  logic [31:0] wshift;

  always_comb begin
    off     = lane_offset(size_i, addr_lo_i);
    sel     = lane_sel(size_i, addr_lo_i);
    shifted = rdata_i >> {off, 3'b000};
    wshift  = wdata_i << {off, 3'b000};

    case (size_i)
      SizeB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      SizeH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      SizeBu:  load_data_o = {24'h0, shifted[7:0]};
      SizeHu:  load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase

    store_word_o = rdata_i;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) store_word_o[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with read-modify-write sub-word stores over a single-ported word memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_size_q, mem_size_d;

  logic        fault;
  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_align u_align (
    .size_i      (mem_size_q),
    .addr_lo_i   (addr_lo_q),
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .store_word_o(store_word)
  );

  always_comb begin
    fault = (req_write ? !(req_size inside {SizeB, SizeH, SizeW})
                       : !(req_size inside {SizeB, SizeH, SizeW, SizeBu, SizeHu}))
            || ({2'b00, req_addr[31:2]} >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    fault = fault || misaligned(req_size, req_addr[1:0]);
`endif
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_lo_d   = req_addr[1:0];
          wdata_d     = req_wdata;
          mem_addr_d  = {2'b00, req_addr[31:2]};
          mem_size_d  = req_size;
          req_ready_d = 1'b0;
          if (fault) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (req_write && (req_size == SizeW)) begin
            state_d     = StWr;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d = StRd;
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        if (write_q) begin
          state_d     = StWr;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_word;
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end
      end
      StWr: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
      StResp: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_size_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the attached memory.
REQ-002 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  processor request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  3  RISC-V funct3 access code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  load result, extended.
REQ-012 SHALL have port rsp_err  output  1  access fault, valid with rsp_valid.
REQ-013 SHALL have port mem_addr  output  32  word index, i.e. latched req_addr[31:2].
REQ-014 SHALL have port mem_we  output  1  memory write enable.
REQ-015 SHALL have port mem_wdata  output  32  full word to write.
REQ-016 SHALL have port mem_size  output  3  latched req_size, informational.
REQ-017 SHALL have port mem_rdata  input  32  memory read data, registered one cycle after mem_addr with mem_we=0.

Function
REQ-018 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL, in IDLE with req_valid, latch write, size, addr and wdata, then go: fault -> RESP; load -> RD; SW -> WR; SB/SH -> RD (read-modify-write).
REQ-020 SHALL go RD -> CAP unconditionally; in CAP, a load registers the extracted result and goes to RESP, and SB/SH registers the merged word and goes to WR.
REQ-021 SHALL drive mem_we=1 only in WR, with mem_wdata = req_wdata for SW or the merged word for SB/SH; WR -> RESP.
REQ-022 SHALL pulse rsp_valid for exactly one cycle in RESP, then return to IDLE; rsp_rdata holds until the next response, and equals 0 for stores and faults.
REQ-023 SHALL give latency, counted in cycles after the accepting edge: fault 1, SW 2, load 3, SB/SH 4.
REQ-024 SHALL use little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1].
REQ-025 SHALL extend loads as follows: LB=000 and LH=001 sign-extend, LW=010 passes through, LBU=100 and LHU=101 zero-extend.
REQ-026 SHALL accept store codes SB=000, SH=001 and SW=010; an SB/SH merge replaces only the addressed lanes.
REQ-027 SHALL fault on any other size code, and on a word index >= MEM_WORDS; a faulting access issues no mem_we.
REQ-028 SHALL ignore req_valid outside IDLE; back-to-back requests are accepted in the IDLE cycle that follows RESP.

Reset
REQ-029 SHALL force state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0 and mem_size=0 while RESET is high.
REQ-030 SHALL, on RESET mid-transaction, drop that transaction with no response and no subsequent memory write.

Configuration
REQ-031 SHALL, with LSU_MISALIGN_TRAP_EN defined, fault on a halfword access with addr[0]=1 or a word access with addr[1:0]!=0.
REQ-032 SHALL, without LSU_MISALIGN_TRAP_EN, silently align such addresses down (halfword clears bit 0, word clears bits 1:0).

Structure
REQ-033 SHALL take the funct3 codes, state encoding and a lane-select function from a shared package lsu_pkg.
REQ-034 SHALL place lane extraction, extension and store merging in a combinational sub-module lsu_align.

Verification
REQ-035 SHALL cover: SW addr 0x4 data 0x8899AABB, then LW 0x4 -> rsp_rdata 0x8899AABB, rsp_valid 3 cycles after accept.
REQ-036 SHALL cover: LB 0x5 -> 0xFFFFFFAA; LBU 0x5 -> 0x000000AA; LHU 0x6 -> 0x00008899.
REQ-037 SHALL cover: SB 0x6 data 0x12 -> one mem_we in WR, word 1 becomes 0x8812AABB, response 4 cycles after accept.
REQ-038 SHALL cover: LH 0x5 -> with the macro, rsp_err=1 after 1 cycle and no memory access; without it, 0xFFFFAABB.
REQ-039 SHALL cover: LW 0x100 (word index 64) -> rsp_err=1 and mem_we stays 0; size code 011 -> rsp_err=1.
REQ-040 SHALL cover: RESET asserted in CAP of an SB -> no mem_we, no rsp_valid, word unchanged, req_ready=1.
